// File: rtl/alu_div_pkg.sv
// Shared definitions for the iterative RV64M divider: data width, FSM encoding and
// iteration counter width.
package alu_div_pkg;

  localparam int XLEN        = 64;
  localparam int DIV_CNT_LEN = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division step: shift in the next dividend bit, then trial-subtract
// the divisor and keep the difference if it did not borrow.
module alu_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] div_i,
  input  logic         bit_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  // One extra bit of headroom: the shifted remainder can exceed 2^W - 1.
  logic [W:0] trial;

  assign trial = {rem_i, bit_i} - {1'b0, div_i};
  assign q_o   = ~trial[W];
  assign rem_o = q_o ? trial[W-1:0] : {rem_i[W-2:0], bit_i};

endmodule

// File: rtl/alu_div.sv
// Iterative RV64M divide/remainder unit with valid/ready handshakes on both sides,
// single-cycle special cases and flush support.
module alu_div
  import alu_div_pkg::*;
#(
  parameter int XLEN = alu_div_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid_i,
  output logic            div_ready_o,
  input  logic [XLEN-1:0] div_a_i,
  input  logic [XLEN-1:0] div_b_i,
  input  logic            div_signed_i,
  input  logic            div_word_i,
  input  logic            div_rem_i,
  input  logic            flush_i,
  output logic            div_valid_o,
  input  logic            div_ready_i,
  output logic [XLEN-1:0] div_out
);

  localparam logic [DIV_CNT_LEN-1:0] CNT_LAST   = DIV_CNT_LEN'(XLEN - 1);
  localparam logic [DIV_CNT_LEN-1:0] CNT_LAST_W = DIV_CNT_LEN'(31);
  localparam logic [XLEN-1:0]        XLEN_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e             state_q;
  logic                   ready_q;
  logic                   valid_q;
  logic [XLEN-1:0]        out_q;
  logic [XLEN-1:0]        rem_q;
  logic [XLEN-1:0]        quo_q;
  logic [XLEN-1:0]        dvs_q;
  logic [DIV_CNT_LEN-1:0] cnt_q;
  logic                   word_q;
  logic                   rem_sel_q;
  logic                   neg_quo_q;
  logic                   neg_rem_q;

  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_res, spec_res, quo_init;
  logic            a_neg, b_neg, b_zero, ovf;

  // Request decode: operand extension, magnitudes and special-case detection.
  always_comb begin
    if (div_word_i) begin
      a_ext = {{(XLEN-32){div_signed_i & div_a_i[31]}}, div_a_i[31:0]};
      b_ext = {{(XLEN-32){div_signed_i & div_b_i[31]}}, div_b_i[31:0]};
      a_res = {{(XLEN-32){div_a_i[31]}}, div_a_i[31:0]};
      ovf   = div_signed_i && (div_a_i[31:0] == 32'h8000_0000) && (div_b_i[31:0] == 32'hFFFF_FFFF);
    end else begin
      a_ext = div_a_i;
      b_ext = div_b_i;
      a_res = div_a_i;
      ovf   = div_signed_i && (div_a_i == XLEN_MIN) && (&div_b_i);
    end
    a_neg    = div_signed_i & a_ext[XLEN-1];
    b_neg    = div_signed_i & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    b_zero   = (b_ext == '0);
    spec_res = div_rem_i ? (b_zero ? a_res : '0) : (b_zero ? '1 : a_res);
    // Word dividends start in the top half so the MSB-first shift sees them first.
    quo_init = div_word_i ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
  end

  logic [XLEN-1:0] step_rem, quo_nxt, quo_fix, rem_fix, res_sel, fin_res;
  logic            step_q;

  alu_div_step #(.W(XLEN)) u_step (
    .rem_i (rem_q),
    .div_i (dvs_q),
    .bit_i (quo_q[XLEN-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    quo_nxt = {quo_q[XLEN-2:0], step_q};
    quo_fix = neg_quo_q ? -quo_nxt : quo_nxt;
    rem_fix = neg_rem_q ? -step_rem : step_rem;
    res_sel = rem_sel_q ? rem_fix : quo_fix;
    fin_res = word_q ? {{(XLEN-32){res_sel[31]}}, res_sel[31:0]} : res_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      out_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      word_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush_i) begin
      // Also covers a DONE handshake in the same cycle: both land in IDLE.
      state_q <= DIV_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (div_valid_i && ready_q) begin
            ready_q   <= 1'b0;
            word_q    <= div_word_i;
            rem_sel_q <= div_rem_i;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (b_zero || ovf) begin
              out_q   <= spec_res;
              valid_q <= 1'b1;
              state_q <= DIV_DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= quo_init;
              dvs_q   <= b_mag;
              cnt_q   <= '0;
              state_q <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_q <= step_rem;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == (word_q ? CNT_LAST_W : CNT_LAST)) begin
            out_q   <= fin_res;
            valid_q <= 1'b1;
            state_q <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (div_ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= DIV_IDLE;
          end
        end
        default: begin
          state_q <= DIV_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign div_ready_o = ready_q;
  assign div_valid_o = valid_q;
  assign div_out     = out_q;

endmodule

// File: tb/tb_alu_div.sv
// Directed-vector bench for alu_div: results, latencies, backpressure and flush.
module tb_alu_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid_i;
  logic        div_ready_o;
  logic [63:0] div_a_i;
  logic [63:0] div_b_i;
  logic        div_signed_i;
  logic        div_word_i;
  logic        div_rem_i;
  logic        flush_i;
  logic        div_valid_o;
  logic        div_ready_i;
  logic [63:0] div_out;

  int errors = 0;
  int checks = 0;

  alu_div #(.XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_valid_i  (div_valid_i),
    .div_ready_o  (div_ready_o),
    .div_a_i      (div_a_i),
    .div_b_i      (div_b_i),
    .div_signed_i (div_signed_i),
    .div_word_i   (div_word_i),
    .div_rem_i    (div_rem_i),
    .flush_i      (flush_i),
    .div_valid_o  (div_valid_o),
    .div_ready_i  (div_ready_i),
    .div_out      (div_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for div_valid_o; the result stays pending.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic w, input logic r, output logic [63:0] res,
                        output logic [63:0] lat);
    @(negedge clk);
    div_a_i = a; div_b_i = b; div_signed_i = s; div_word_i = w; div_rem_i = r;
    div_valid_i = 1'b1;
    @(posedge clk); #1;
    div_valid_i = 1'b0;
    div_a_i = '0; div_b_i = '0;
    lat = 64'd1;
    while (!div_valid_o && lat < 64'd200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = div_out;
    $display("op a=%h b=%h s=%0d w=%0d r=%0d -> %h latency=%0d", a, b, s, w, r, res, lat);
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    div_ready_i = 1'b1;
    @(posedge clk); #1;
    div_ready_i = 1'b0;
    chk({tag, "_ready_after"}, {63'd0, div_ready_o}, 64'd1);
    chk({tag, "_valid_after"}, {63'd0, div_valid_o}, 64'd0);
  endtask

  task automatic op_check(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic w, input logic r,
                          input logic [63:0] exp_res, input logic [63:0] exp_lat);
    logic [63:0] res, lat;
    run_op(a, b, s, w, r, res, lat);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_lat"}, lat, exp_lat);
    accept(tag);
  endtask

  task automatic count_valid(input int cycles, output logic [63:0] seen);
    seen = '0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (div_valid_o) seen++;
    end
  endtask

  initial begin
    logic [63:0] res, lat, seen, held;
    rst = 1'b1; div_valid_i = 1'b0; div_a_i = '0; div_b_i = '0;
    div_signed_i = 1'b0; div_word_i = 1'b0; div_rem_i = 1'b0;
    flush_i = 1'b0; div_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", {63'd0, div_ready_o}, 64'd1);
    chk("reset_valid", {63'd0, div_valid_o}, 64'd0);
    chk("reset_out",   div_out, 64'd0);

    op_check("div_m7_2",   -64'sd7, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd65);
    op_check("rem_m7_2",   -64'sd7, 64'd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd65);
    op_check("div_7_m2",   64'd7, -64'sd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd65);
    op_check("rem_7_m2",   64'd7, -64'sd2, 1'b1, 1'b0, 1'b1, 64'd1, 64'd65);
    op_check("divu_big_3", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 1'b0, 64'h5555_5555_5555_5555, 64'd65);
    op_check("divu_5_0",   64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    op_check("remu_5_0",   64'd5, 64'd0, 1'b0, 1'b0, 1'b1, 64'd5, 64'd1);
    op_check("divw_5_hi",  64'd5, 64'h1_0000_0000, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    op_check("div_ovf",    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd1);
    op_check("rem_ovf",    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'd0, 64'd1);
    op_check("divw_ovf",   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'd1);
    op_check("divuw_ff_1", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd33);
    op_check("remw_m7_2",  -64'sd7, 64'd2, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd33);
    op_check("divw_m8_3",  64'h1234_5678_FFFF_FFF8, 64'd3, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd33);
    op_check("remuw_f_10", 64'hABCD_0000_FFFF_FFFF, 64'h10, 1'b0, 1'b1, 1'b1, 64'd15, 64'd33);

    // Backpressure: result must hold while the consumer is not ready.
    run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, res, lat);
    chk("bp_res", res, 64'd14);
    held = res;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_stable", div_out, held);
      chk("bp_valid_held", {63'd0, div_valid_o}, 64'd1);
      chk("bp_ready_low",  {63'd0, div_ready_o}, 64'd0);
    end
    accept("bp");

    // Flush at CALC iteration 10: unit returns to IDLE and never reports a result.
    @(negedge clk);
    div_a_i = 64'd1000; div_b_i = 64'd3; div_signed_i = 1'b0; div_word_i = 1'b0; div_rem_i = 1'b0;
    div_valid_i = 1'b1;
    @(posedge clk); #1;
    div_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    $display("flush during CALC: ready=%0d valid=%0d", div_ready_o, div_valid_o);
    chk("flush_calc_ready", {63'd0, div_ready_o}, 64'd1);
    chk("flush_calc_valid", {63'd0, div_valid_o}, 64'd0);
    count_valid(80, seen);
    chk("flush_calc_no_result", seen, 64'd0);

    op_check("divu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 64'd65);
    op_check("remu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 64'd2, 64'd65);

    // Flush and request in the same cycle: the request is dropped.
    @(negedge clk);
    div_a_i = 64'd100; div_b_i = 64'd7; div_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    div_valid_i = 1'b0; flush_i = 1'b0;
    $display("flush+valid: ready=%0d valid=%0d", div_ready_o, div_valid_o);
    chk("flush_req_ready", {63'd0, div_ready_o}, 64'd1);
    count_valid(80, seen);
    chk("flush_req_no_result", seen, 64'd0);

    // Flush while a result is pending without acceptance discards it.
    run_op(64'd5, 64'd0, 1'b0, 1'b0, 1'b0, res, lat);
    chk("flush_done_pre_valid", {63'd0, div_valid_o}, 64'd1);
    @(negedge clk) flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    $display("flush in DONE: ready=%0d valid=%0d", div_ready_o, div_valid_o);
    chk("flush_done_valid", {63'd0, div_valid_o}, 64'd0);
    chk("flush_done_ready", {63'd0, div_ready_o}, 64'd1);

    // Reset in the middle of a computation.
    @(negedge clk);
    div_a_i = 64'd77; div_b_i = 64'd5; div_valid_i = 1'b1;
    @(posedge clk); #1;
    div_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", {63'd0, div_ready_o}, 64'd1);
    chk("midrst_valid", {63'd0, div_valid_o}, 64'd0);
    chk("midrst_out",   div_out, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
